// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding, reset/vector constants and the IF/ID bundle
// shared by the fetch stage and its hold buffer.
package fetch_pkg;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        PARK
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_1000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_2000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        tlb_miss;
        logic        valid;
    } fetch_bundle_t;

    function automatic fetch_bundle_t bubble(input logic [31:0] nop);
        fetch_bundle_t b;
        b.instr    = nop;
        b.pc       = 32'h0;
        b.pc_next  = 32'h0;
        b.tlb_miss = 1'b0;
        b.valid    = 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: single-outstanding request/response link between the
// fetch stage (master) and the instruction cache (slave).
interface fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        tlb_miss;

    modport master (
        output req, addr,
        input  ready, rvalid, rdata, tlb_miss
    );

    modport slave (
        input  req, addr,
        output ready, rvalid, rdata, tlb_miss
    );
endinterface

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry skid buffer that parks a fetched word
// while decode is not accepting.
module fetch_hold_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          drain,
    input  logic          clear,
    input  fetch_bundle_t data_in,
    output fetch_bundle_t data,
    output logic          full
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            full <= 1'b0;
            data <= bubble(NOP_WORD);
        end else if (load) begin
            full <= 1'b1;
            data <= data_in;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, icache requester and IF/ID stage register.
// Define FETCH_PERF_CNT_EN to add perf_fetched / perf_stall_cycles.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_reg,
    input  logic        block_pipe_data_cache,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        tlb_miss_trap,
    input  logic        iret,
    input  logic [31:0] iret_target,
    fetch_if.master     imem,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_next_out,
    output logic        tlb_miss_out,
    output logic        valid_out,
    output logic        icache_stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    fetch_state_t  state, state_nxt;
    logic [31:0]   pc, pc_nxt, target;
    fetch_bundle_t stage, stage_nxt, resp, hold_data;
    logic          advance, redirect, resp_take;
    logic          hold_full, hold_load, hold_drain;

    assign advance  = en_reg & ~block_pipe_data_cache;
    assign redirect = tlb_miss_trap | iret | branch_taken;

    always_comb begin
        target = word_align(branch_target);
        if (tlb_miss_trap) begin
            target = word_align(EXC_VECTOR);
        end else if (iret) begin
            target = word_align(iret_target);
        end
    end

    // A response only counts when it answers a live request.
    assign resp_take = (state == WAIT) & imem.rvalid & ~redirect;

    always_comb begin
        resp.instr    = imem.tlb_miss ? NOP_WORD : imem.rdata;
        resp.pc       = pc;
        resp.pc_next  = pc + 32'd4;
        resp.tlb_miss = imem.tlb_miss;
        resp.valid    = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        stage_nxt  = stage;
        hold_load  = 1'b0;
        hold_drain = 1'b0;
        if (redirect) begin
            pc_nxt    = target;
            stage_nxt = bubble(NOP_WORD);
            unique case (state)
                REQ:         state_nxt = imem.ready ? DRAIN : REQ;
                WAIT, DRAIN: state_nxt = imem.rvalid ? REQ : DRAIN;
                default:     state_nxt = REQ;
            endcase
        end else begin
            unique case (state)
                REQ: begin
                    if (imem.ready) state_nxt = WAIT;
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        if (imem.tlb_miss) begin
                            state_nxt = PARK;
                        end else if (advance) begin
                            state_nxt = REQ;
                            pc_nxt    = pc + 32'd4;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (advance) begin
                        state_nxt = REQ;
                        pc_nxt    = pc + 32'd4;
                    end
                end
                DRAIN: begin
                    if (imem.rvalid) state_nxt = REQ;
                end
                default: state_nxt = state;
            endcase
            if (advance) begin
                if (resp_take) begin
                    stage_nxt = resp;
                end else if (hold_full) begin
                    stage_nxt  = hold_data;
                    hold_drain = 1'b1;
                end else begin
                    stage_nxt = bubble(NOP_WORD);
                end
            end else if (resp_take) begin
                hold_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
            pc    <= RESET_PC;
            stage <= bubble(NOP_WORD);
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            stage <= stage_nxt;
        end
    end

    fetch_hold_buffer #(
        .NOP_WORD(NOP_WORD)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .load    (hold_load),
        .drain   (hold_drain),
        .clear   (redirect),
        .data_in (resp),
        .data    (hold_data),
        .full    (hold_full)
    );

    assign imem.req  = (state == REQ) & ~reset;
    assign imem.addr = pc;

    assign icache_stall = ((state == REQ) | (state == WAIT) | (state == DRAIN))
                        & ~resp_take;

    assign instr_out    = stage.instr;
    assign pc_out       = stage.pc;
    assign pc_next_out  = stage.pc_next;
    assign tlb_miss_out = stage.tlb_miss;
    assign valid_out    = stage.valid;

`ifdef FETCH_PERF_CNT_EN
    logic fetched;

    assign fetched = advance & ~redirect & (resp_take | hold_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= 32'h0;
            perf_stall_cycles <= 32'h0;
        end else begin
            if (fetched && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (icache_stall && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic against an event-level model
// of the fetch contract; a monitor scores the IF/ID register every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] EXC    = 32'h0000_2000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        miss;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_reg = 1'b0;
    logic        block = 1'b0;
    logic        br = 1'b0;
    logic        trap = 1'b0;
    logic        iret = 1'b0;
    logic [31:0] br_tgt = 32'h0;
    logic [31:0] iret_tgt = 32'h0;
    logic [31:0] instr_out, pc_out, pc_next_out;
    logic        tlb_miss_out, valid_out, icache_stall;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall_cycles;
`endif

    fetch_if imem();

    fetch_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .en_reg                (en_reg),
        .block_pipe_data_cache (block),
        .branch_taken          (br),
        .branch_target         (br_tgt),
        .tlb_miss_trap         (trap),
        .iret                  (iret),
        .iret_target           (iret_tgt),
        .imem                  (imem),
        .instr_out             (instr_out),
        .pc_out                (pc_out),
        .pc_next_out           (pc_next_out),
        .tlb_miss_out          (tlb_miss_out),
        .valid_out             (valid_out),
        .icache_stall          (icache_stall)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched          (perf_fetched),
        .perf_stall_cycles     (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [63:0] cnt_q[$];

    // stimulus for the next cycle
    bit          s_rst, s_en, s_blk, s_br, s_trap, s_iret;
    logic [31:0] s_bt, s_it;

    // cache and model state
    bit          c_busy, c_live, c_miss;
    int          c_lat;
    logic [31:0] c_addr, m_pc;
    bit          m_park, m_held_v;
    exp_t        m_stage, m_held;
    int unsigned m_fetched, m_stalls;

    int lat_cfg = 0;
    int rdy_pct = 100;
    int miss_pct = 0;
    bit force_miss = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) * 32'h9E37_79B1 + 32'h1;
    endfunction

    function automatic exp_t bubble_e();
        exp_t e;
        e = '{instr: NOP, pc: 32'h0, pc_next: 32'h0, miss: 1'b0, valid: 1'b0};
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        bit          adv, redir, deliver, exp_req, exp_stall;
        logic [31:0] tgt, pc0;
        exp_t        w;
        @(negedge clk);
        reset    = s_rst;
        en_reg   = s_en;
        block    = s_blk;
        br       = s_br;
        br_tgt   = s_bt;
        trap     = s_trap;
        iret     = s_iret;
        iret_tgt = s_it;
        imem.rvalid   = 1'b0;
        imem.tlb_miss = 1'b0;
        imem.rdata    = $urandom;
        if (!reset && c_busy) begin
            if (c_lat == 0) begin
                imem.rvalid   = 1'b1;
                imem.tlb_miss = c_miss;
                imem.rdata    = mem_word(c_addr);
            end else begin
                c_lat--;
            end
        end
        imem.ready = ($urandom_range(99) < rdy_pct);
        #2;
        if (reset) begin
            check("req_in_reset", {31'h0, imem.req}, 32'h0);
            m_pc      = RST_PC;
            c_busy    = 1'b0;
            c_live    = 1'b0;
            m_park    = 1'b0;
            m_held_v  = 1'b0;
            m_stage   = bubble_e();
            m_fetched = 0;
            m_stalls  = 0;
        end else begin
            adv   = en_reg && !block;
            redir = trap || iret || br;
            tgt   = trap ? EXC :
                    iret ? {iret_tgt[31:2], 2'b00} : {br_tgt[31:2], 2'b00};
            pc0   = m_pc;
            exp_req = !m_park && !c_busy && !m_held_v;
            check("imem_req", {31'h0, imem.req}, {31'h0, exp_req});
            if (exp_req) check("imem_addr", imem.addr, pc0);
            deliver   = imem.rvalid && c_live && !redir;
            exp_stall = !m_park && !m_held_v && !deliver;
            check("icache_stall", {31'h0, icache_stall}, {31'h0, exp_stall});
            if (exp_stall) m_stalls++;
            w = '{instr: c_miss ? NOP : mem_word(c_addr), pc: c_addr,
                  pc_next: c_addr + 32'd4, miss: c_miss, valid: 1'b1};
            if (imem.rvalid) c_busy = 1'b0;
            if (redir) begin
                m_pc     = tgt;
                m_stage  = bubble_e();
                m_held_v = 1'b0;
                m_park   = 1'b0;
                c_live   = 1'b0;
            end else begin
                if (deliver) begin
                    if (c_miss) m_park = 1'b1;
                    else m_pc = c_addr + 32'd4;
                end
                if (adv) begin
                    if (deliver) begin
                        m_stage = w;
                        m_fetched++;
                    end else if (m_held_v) begin
                        m_stage  = m_held;
                        m_held_v = 1'b0;
                        m_fetched++;
                    end else begin
                        m_stage = bubble_e();
                    end
                end else if (deliver) begin
                    m_held   = w;
                    m_held_v = 1'b1;
                end
            end
            if (exp_req && imem.ready) begin
                c_busy = 1'b1;
                c_live = !redir;
                c_addr = pc0;
                c_lat  = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(3));
                c_miss = force_miss || ($urandom_range(99) < miss_pct);
            end
        end
        exp_q.push_back(m_stage);
        cnt_q.push_back({m_fetched, m_stalls});
    endtask

    task automatic clear_redirects();
        s_br   = 1'b0;
        s_trap = 1'b0;
        s_iret = 1'b0;
    endtask

    initial begin
        exp_t        e;
        logic [63:0] c;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = cnt_q.pop_front();
                checks++;
                if ({instr_out, pc_out, pc_next_out, tlb_miss_out, valid_out} !== e) begin
                    errors++;
                    $display("FAIL stage_reg @%0t: got %h/%h/%h/%b/%b expected %h/%h/%h/%b/%b",
                             $time, instr_out, pc_out, pc_next_out, tlb_miss_out,
                             valid_out, e.instr, e.pc, e.pc_next, e.miss, e.valid);
                end
`ifdef FETCH_PERF_CNT_EN
                checks++;
                if ({perf_fetched, perf_stall_cycles} !== c) begin
                    errors++;
                    $display("FAIL perf @%0t: got %0d/%0d expected %0d/%0d", $time,
                             perf_fetched, perf_stall_cycles, c[63:32], c[31:0]);
                end
`endif
            end
        end
    end

    initial begin
        bit wrap_seen;
        imem.ready = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = 32'h0;
        imem.tlb_miss = 1'b0;
        s_rst = 1'b1; s_en = 1'b1; s_blk = 1'b0;
        s_bt = 32'h0; s_it = 32'h0;
        clear_redirects();
        repeat (2) cycle();
        s_rst = 1'b0;

        // boot from RESET_PC with a single-cycle cache
        repeat (8) cycle();

        // decode stalled while a response lands
        s_en = 1'b0;
        repeat (6) cycle();
        s_en = 1'b1;
        repeat (6) cycle();

        // branch while waiting on a slow response
        lat_cfg = 2;
        for (int i = 0; i < 8 && !(c_busy && c_live); i++) cycle();
        s_br = 1'b1; s_bt = 32'h0000_2043;
        cycle();
        clear_redirects();
        repeat (8) cycle();

        // faulting fetch parks the stage until a trap
        lat_cfg = 0;
        force_miss = 1'b1;
        for (int i = 0; i < 8 && !m_park; i++) cycle();
        force_miss = 1'b0;
        repeat (4) cycle();
        s_trap = 1'b1;
        cycle();
        clear_redirects();
        repeat (4) cycle();

        // redirect priority
        s_trap = 1'b1; s_iret = 1'b1; s_it = 32'h0000_3000;
        s_br = 1'b1; s_bt = 32'h0000_4000;
        cycle();
        clear_redirects();
        repeat (4) cycle();
        s_iret = 1'b1; s_br = 1'b1;
        cycle();
        clear_redirects();
        repeat (4) cycle();

        // PC wrap at the top of the address space
        s_br = 1'b1; s_bt = 32'hFFFF_FFFC;
        cycle();
        clear_redirects();
        wrap_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            @(posedge clk);
            #2;
            if (valid_out && pc_out == 32'hFFFF_FFFC) begin
                wrap_seen = 1'b1;
                check("wrap_pc_next", pc_next_out, 32'h0000_0000);
            end
        end
        check("wrap_seen", {31'h0, wrap_seen}, 32'h1);

        // random traffic
        lat_cfg = -1;
        rdy_pct = 70;
        miss_pct = 4;
        repeat (4000) begin
            s_rst  = ($urandom_range(199) == 0);
            s_en   = ($urandom_range(99) < 80);
            s_blk  = ($urandom_range(99) < 10);
            s_br   = ($urandom_range(99) < 5);
            s_trap = ($urandom_range(99) < 1);
            s_iret = ($urandom_range(99) < 2);
            s_bt   = $urandom;
            s_it   = $urandom;
            cycle();
        end
        s_rst = 1'b0;
        clear_redirects();
        repeat (3) cycle();
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
